// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad matrix scanner
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} kp_state_t;

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_t;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// rtl/keypad_row_driver.sv - dwell counter, row index and one-cold row drive
module keypad_row_driver #(
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ROWS-1:0]         row,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    sample,
  output logic                    scan_done
);

  localparam int RIW = $clog2(ROWS);
  localparam int DW  = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell;

  // Columns are sampled on the last dwell cycle so the synchroniser has settled.
  assign sample    = (dwell == DW'(SCAN_DIV - 1));
  assign scan_done = sample && (row_idx == RIW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= '0;
      row     <= ~ROWS'(1);
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= (row_idx == RIW'(ROWS - 1)) ? '0 : row_idx + RIW'(1);
      row     <= {row[ROWS-2:0], row[ROWS-1]};
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - R x C keypad scanner with whole-scan debounce
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CODE_W         = code_w(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int RIW = $clog2(ROWS);
  localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);

  logic [RIW-1:0]    row_idx;
  logic              sample;
  logic              scan_done;
  logic [COLS-1:0]   col_s1, col_s2;

  logic [1:0]        acc_cnt, row_cnt, tot_cnt;
  logic [CODE_W-1:0] acc_first, tot_first;
  logic [CODE_W-1:0] row_code;
  int                first_c;
  logic              found;
  scan_res_t         res;

  kp_state_t         state, state_n;
  logic [CODE_W-1:0] cand, cand_n, code_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic              valid_n, held_n, release_n;

  keypad_row_driver #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_row_driver (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .row_idx   (row_idx),
    .sample    (sample),
    .scan_done (scan_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // Hit counts saturate at 2: only none / one / many matters to the classifier.
  always_comb begin
    row_cnt = '0;
    first_c = 0;
    found   = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2[c]) begin
        if (!found) begin
          first_c = c;
          found   = 1'b1;
        end
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
      end
    end
    row_code = CODE_W'(int'(row_idx) * COLS + first_c);

    if (acc_cnt == 2'd0)      tot_cnt = row_cnt;
    else if (row_cnt == 2'd0) tot_cnt = acc_cnt;
    else                      tot_cnt = 2'd2;
    tot_first = (acc_cnt != 2'd0) ? acc_first : row_code;

    if (tot_cnt == 2'd0)      res = RES_NONE;
    else if (tot_cnt == 2'd1) res = RES_SINGLE;
    else                      res = RES_MULTI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt   <= '0;
      acc_first <= '0;
      multi_key <= 1'b0;
    end else if (sample) begin
      acc_cnt   <= scan_done ? '0 : tot_cnt;
      acc_first <= scan_done ? '0 : tot_first;
      if (scan_done) multi_key <= (res == RES_MULTI);
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    held_n    = key_held;
    release_n = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (res == RES_SINGLE) begin
            state_n = PRESS_CHK;
            cand_n  = tot_first;
            cnt_n   = CW'(1);
          end
        end
        PRESS_CHK: begin
          if (res == RES_SINGLE && tot_first == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              cnt_n   = CW'(DEBOUNCE_SCANS);
              state_n = HELD;
              code_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end
          end else if (res == RES_SINGLE) begin
            cand_n = tot_first;
            cnt_n  = CW'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (res == RES_NONE) begin
            state_n = RELEASE_CHK;
            cnt_n   = CW'(1);
          end
        end
        RELEASE_CHK: begin
          if (res == RES_NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              cnt_n     = '0;
              state_n   = IDLE;
              release_n = 1'b1;
              held_n    = 1'b0;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_held    <= held_n;
      key_release <= release_n;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed bench for the keypad matrix scanner
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_key;

  logic [15:0] keys = '0;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  keypad_matrix_scanner #(
    .ROWS           (4),
    .COLS           (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its column to the driven row.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_row;
    one  = 4'b0001;
    keys = '0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      exp_row = ~(one << ((cyc / 4) % 4));
      checks++;
      if (row !== exp_row) begin
        failures++;
        $display("FAIL reset_row cyc=%0d got=%b exp=%b", cyc, row, exp_row);
      end
      checks++;
      if ({key_valid, key_held, key_release, multi_key, key_code} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc,
                 {key_valid, key_held, key_release, multi_key, key_code});
      end
    end
  endtask

  task automatic test_bounce();
    int vcount = 0;
    keys = 16'h0200;
    do_reset();
    while (cyc < 112) begin
      tick();
      if (key_valid) vcount++;
      if (cyc == 32) keys = '0;
      if (cyc == 48) keys = 16'h0200;
      if (cyc == 80) keys = '0;
    end
    checks++;
    if (vcount !== 0) begin
      failures++;
      $display("FAIL bounce_valid got=%0d exp=0", vcount);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL bounce_state got=%0d exp=%0d", dut.state, IDLE);
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL bounce_held got=%b exp=0", key_held);
    end
  endtask

  task automatic test_press();
    int vcount = 0;
    int vcyc   = -1;
    keys = 16'h0200;
    do_reset();
    while (cyc < 80) begin
      tick();
      if (key_valid) begin
        vcount++;
        vcyc = cyc;
      end
      checks++;
      if (key_held !== (cyc >= 48)) begin
        failures++;
        $display("FAIL press_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc >= 48);
      end
    end
    checks++;
    if (vcount !== 1 || vcyc !== 48) begin
      failures++;
      $display("FAIL press_valid count=%0d at=%0d exp count=1 at=48", vcount, vcyc);
    end
    checks++;
    if (key_code !== 4'd9) begin
      failures++;
      $display("FAIL press_code got=%0d exp=9", key_code);
    end
  endtask

  task automatic test_release();
    int rcount = 0;
    int rcyc   = -1;
    int vcount = 0;
    keys = '0;
    while (cyc < 160) begin
      tick();
      if (key_release) begin
        rcount++;
        rcyc = cyc;
      end
      if (key_valid) vcount++;
      checks++;
      if (key_held !== (cyc < 128)) begin
        failures++;
        $display("FAIL release_held cyc=%0d got=%b exp=%b", cyc, key_held, cyc < 128);
      end
    end
    checks++;
    if (rcount !== 1 || rcyc !== 128) begin
      failures++;
      $display("FAIL release_pulse count=%0d at=%0d exp count=1 at=128", rcount, rcyc);
    end
    checks++;
    if (vcount !== 0) begin
      failures++;
      $display("FAIL release_valid got=%0d exp=0", vcount);
    end
    checks++;
    if (key_code !== 4'd9) begin
      failures++;
      $display("FAIL release_code got=%0d exp=9", key_code);
    end
  endtask

  task automatic test_multi();
    int vcount = 0;
    int vcyc   = -1;
    keys = 16'h8001;
    while (cyc < 230) begin
      tick();
      if (key_valid) begin
        vcount++;
        vcyc = cyc;
      end
      checks++;
      if (multi_key !== (cyc >= 176 && cyc < 192)) begin
        failures++;
        $display("FAIL multi_flag cyc=%0d got=%b exp=%b", cyc, multi_key,
                 cyc >= 176 && cyc < 192);
      end
      if (cyc == 223) begin
        checks++;
        if (key_code !== 4'd9) begin
          failures++;
          $display("FAIL multi_code_before got=%0d exp=9", key_code);
        end
      end
      if (cyc == 176) keys = 16'h0001;
    end
    checks++;
    if (vcount !== 1 || vcyc !== 224) begin
      failures++;
      $display("FAIL multi_valid count=%0d at=%0d exp count=1 at=224", vcount, vcyc);
    end
    checks++;
    if (key_code !== 4'd0) begin
      failures++;
      $display("FAIL multi_code got=%0d exp=0", key_code);
    end
    checks++;
    if (key_held !== 1'b1) begin
      failures++;
      $display("FAIL multi_held got=%b exp=1", key_held);
    end
  endtask

  task automatic test_rst_mid();
    int vcount = 0;
    int vcyc   = -1;
    int rcount = 0;
    do_reset();
    checks++;
    if ({key_held, key_release, key_valid, multi_key} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b exp=0000",
               {key_held, key_release, key_valid, multi_key});
    end
    checks++;
    if (row !== 4'b1110) begin
      failures++;
      $display("FAIL rstmid_row got=%b exp=1110", row);
    end
    while (cyc < 64) begin
      tick();
      if (key_valid) begin
        vcount++;
        vcyc = cyc;
      end
      if (key_release) rcount++;
    end
    checks++;
    if (vcount !== 1 || vcyc !== 48) begin
      failures++;
      $display("FAIL rstmid_valid count=%0d at=%0d exp count=1 at=48", vcount, vcyc);
    end
    checks++;
    if (rcount !== 0) begin
      failures++;
      $display("FAIL rstmid_release got=%0d exp=0", rcount);
    end
    checks++;
    if (key_code !== 4'd0 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_reaccept code=%0d held=%b exp code=0 held=1", key_code, key_held);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_release();
    test_multi();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised successor to the team's 4x4 keypad scanner: drives an R x C matrix one row at a time, samples the columns, and debounces across whole scans.
- Emits a one-cycle press strobe with a linear key index, a held level, a release strobe and a multi-key (ghost) flag.
- Sits between the keypad pins and the input-decode logic; key-to-symbol mapping is downstream, not here.

Parameters:
- ROWS, 4, number of matrix rows driven (>=2).
- COLS, 4, number of matrix columns sampled (>=2).
- SCAN_DIV, 1000, clk cycles each row is held active (>=3).
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or release (>=2).
- CODE_W, $clog2(ROWS*COLS), width of key_code (derived, do not override).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous to clk, active-high (one clock; reset is synchronous and active-high).
- col  input  COLS  column sense lines, active-low (pressed key pulls its column to 0), asynchronous.
- row  output  ROWS  row drive, active-low one-cold, registered.
- key_code  output  CODE_W  accepted key index = row_idx*COLS + col_idx; holds its value until the next accepted press.
- key_valid  output  1  one-cycle pulse on an accepted press.
- key_held  output  1  level: 1 from the accept cycle until the release is accepted.
- key_release  output  1  one-cycle pulse on an accepted release.
- multi_key  output  1  level: the last completed scan saw more than one key down.

Behaviour:
- Reset (sync): row = all ones except bit0 = 0; dwell counter 0; row index 0; key_code 0; key_valid, key_held, key_release and multi_key = 0; FSM in IDLE; scan accumulators cleared.
- col passes through a 2-flop synchroniser; only the synchronised value is used.
- Row sequencing: a dwell counter counts 0..SCAN_DIV-1. On the last dwell cycle, the synchronised columns are sampled for the current row, the row index advances (ROWS-1 wraps to 0), and row shifts to the next one-cold value. Full scan period = ROWS*SCAN_DIV cycles.
- Scan accumulation: across one scan, count active (0) column bits and record the index of the first hit.
- On sampling row ROWS-1 (scan_done), the result is classified as NONE (0 hits), SINGLE(code) (1 hit) or MULTI (>=2 hits).
- multi_key updates at every scan_done and is registered one cycle after it.
- Debounce FSM, evaluated only on scan_done; cnt saturates at DEBOUNCE_SCANS:
  - IDLE: SINGLE(c) -> PRESS_CHK, cand=c, cnt=1. NONE or MULTI -> stay in IDLE.
  - PRESS_CHK: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> HELD, key_code=cand, key_valid=1 for one cycle, key_held=1. SINGLE(other) -> cand=other, cnt=1. NONE or MULTI -> IDLE.
  - HELD: any non-NONE result -> stay. NONE -> RELEASE_CHK, cnt=1.
  - RELEASE_CHK: NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE, key_release=1 for one cycle, key_held=0 in the same cycle. Any key -> HELD (no new key_valid).
- Latency: key_valid and key_release assert the cycle after the scan_done of the qualifying scan.
- A second key pressed while HELD does not produce key_valid. It raises multi_key only.
- rst mid-operation: everything returns to reset values the next cycle. No release pulse is emitted for a key that was held.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum {IDLE, PRESS_CHK, HELD, RELEASE_CHK};
  - scan result enum {RES_NONE, RES_SINGLE, RES_MULTI};
  - function code_w(rows, cols).
- One sub-module, keypad_row_driver: dwell counter, row index, one-cold row output and the scan_done/sample strobes.
- Classification and debounce FSM stay in the top module.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3; scan period 16 cycles):
1. Reset with no key down -> row sequence 1110, 1101, 1011, 0111, each held 4 cycles, repeating. All other outputs stay 0.
2. Key at row 2, col 1 held steady -> exactly one key_valid pulse at the end of the 3rd full scan, key_code=9, key_held=1. No further pulses while held.
3. Bounce: the same key present 2 scans, absent 1, present 2, then released -> key_valid never asserts and the FSM ends in IDLE.
4. Release after test 2 -> key_release pulses once after 3 consecutive empty scans. key_held falls in the same cycle. key_code stays 9.
5. Keys at (row 0, col 0) and (row 3, col 3) pressed together from IDLE -> multi_key=1 after the first scan and no key_valid. Releasing (3,3) -> (0,0) is accepted 3 scans later with key_code=0.
6. rst asserted for 1 cycle while HELD -> the next cycle shows key_held=0, key_release=0, row=1110. The still-pressed key is re-accepted with a fresh key_valid 3 scans later.
